// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   DEF_DATA_W / DEF_ADDR_W / DEF_NUM_REGS : default geometry (8 x 16-bit)
//   rr_t     : round-robin pointer, RR_ALU (0) prefers the ALU, RR_LD (1) the load unit
//   wb_req_t : one writeback request {dest, data} at the default geometry
package regfile_wb_arbiter_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_ADDR_W   = 3;
  localparam int unsigned DEF_NUM_REGS = 8;

  typedef enum logic {
    RR_ALU = 1'b0,
    RR_LD  = 1'b1
  } rr_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] dest;
    logic [DEF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_hold_buf.sv
// One-entry valid/ready holding buffer for a writeback requester.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid / req_ready : upstream handshake; ready when empty or draining this edge
//   req_dest / req_data   : request captured on a transfer
//   grant                 : arbiter drains the entry at this edge
//   full                  : entry holds a pending write
//   hold_dest / hold_data : the pending write
// Transfers to register 0 are accepted but dropped: they never occupy the entry.
module wb_hold_buf #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_dest,
  input  logic [DATA_W-1:0] req_data,
  input  logic              grant,
  output logic              full,
  output logic [ADDR_W-1:0] hold_dest,
  output logic [DATA_W-1:0] hold_data
);

  logic take;

  assign req_ready = !full || grant;
  assign take      = req_valid && req_ready && (req_dest != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= 1'b0;
      hold_dest <= '0;
      hold_data <= '0;
    end else if (take) begin
      // a refill on the same edge as a drain keeps the entry occupied
      full      <= 1'b1;
      hold_dest <= req_dest;
      hold_data <= req_data;
    end else if (grant) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between the ALU and the load unit.
//   alu_* / ld_*     : writeback requests (valid/ready, dest, data), one holding buffer each
//   issue_en/_dest   : issue stage claims a destination; issue_ready says it is free
//   busy             : per-register pending-write scoreboard (bit 0 always clear)
//   reg_write_*      : registered register-file write port
//   overlap_err      : sticky, set when a claim is attempted on a busy register
// Grants alternate round-robin when both buffers are full.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_dest,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [ADDR_W-1:0]   ld_dest,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_dest,
  output logic                issue_ready,
  output logic [NUM_REGS-1:0] busy,
  output logic                reg_write_en,
  output logic [ADDR_W-1:0]   reg_write_dest,
  output logic [DATA_W-1:0]   reg_write_data,
  output logic                overlap_err
);

  logic              alu_full, ld_full;
  logic              grant_alu, grant_ld;
  logic [ADDR_W-1:0] alu_hold_dest, ld_hold_dest;
  logic [DATA_W-1:0] alu_hold_data, ld_hold_data;
  rr_t               rr;
  logic [NUM_REGS-1:0] busy_next;

  wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (alu_valid),
    .req_ready (alu_ready),
    .req_dest  (alu_dest),
    .req_data  (alu_data),
    .grant     (grant_alu),
    .full      (alu_full),
    .hold_dest (alu_hold_dest),
    .hold_data (alu_hold_data)
  );

  wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ld_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (ld_valid),
    .req_ready (ld_ready),
    .req_dest  (ld_dest),
    .req_data  (ld_data),
    .grant     (grant_ld),
    .full      (ld_full),
    .hold_dest (ld_hold_dest),
    .hold_data (ld_hold_data)
  );

  assign grant_alu = alu_full && (!ld_full || rr == RR_ALU);
  assign grant_ld  = ld_full && (!alu_full || rr == RR_LD);

  assign issue_ready = !busy[issue_dest] || (issue_dest == '0);

  // Clear for the write currently on the port, then set for a new claim,
  // so a claim wins over a completing write to the same register.
  always_comb begin
    busy_next = busy;
    if (reg_write_en) begin
      busy_next[reg_write_dest] = 1'b0;
    end
    if (issue_en && issue_ready && (issue_dest != '0)) begin
      busy_next[issue_dest] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr             <= RR_ALU;
      reg_write_en   <= 1'b0;
      reg_write_dest <= '0;
      reg_write_data <= '0;
      busy           <= '0;
      overlap_err    <= 1'b0;
    end else begin
      busy <= busy_next;
      if (issue_en && !issue_ready) begin
        overlap_err <= 1'b1;
      end
      if (grant_alu) begin
        rr             <= RR_LD;
        reg_write_en   <= 1'b1;
        reg_write_dest <= alu_hold_dest;
        reg_write_data <= alu_hold_data;
      end else if (grant_ld) begin
        rr             <= RR_ALU;
        reg_write_en   <= 1'b1;
        reg_write_dest <= ld_hold_dest;
        reg_write_data <= ld_hold_data;
      end else begin
        reg_write_en <= 1'b0;
      end
    end
  end

endmodule
